// File: rtl/data_mem_responder.sv
// Word-organised data memory that answers RV32I loads/stores after a fixed LATENCY.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them down.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_func3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   state_t      next_state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [2:0]  lat_func3;

   logic [31:0] mem [DEPTH_WORDS];

   logic          func_ok;
   logic          range_ok;
   logic          misalign;
   logic          err;
   logic          access;
   logic [1:0]    off;
   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic [7:0]    byte_val;
   logic [15:0]   half_val;
   logic [31:0]   load_data;
   logic [3:0]    be;
   logic [31:0]   wmask;
   logic [31:0]   wdata_sh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (req_valid) next_state = WAIT;
         WAIT: if (cnt == 4'd0) next_state = RESP;
         RESP: if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign access    = (state == WAIT) && (cnt == 4'd0);

   // Misaligned offsets are rounded down to the access size; the trap build faults them instead.
   always_comb begin
      func_ok  = lat_we ? (lat_func3 inside {3'b000, 3'b001, 3'b010})
                        : (lat_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      range_ok = {2'b00, lat_addr[31:2]} < 32'(DEPTH_WORDS);
      misalign = 1'b0;
      off      = 2'b00;
      be       = 4'b1111;
      case (lat_func3[1:0])
         2'b00: begin
            off = lat_addr[1:0];
            be  = 4'b0001 << lat_addr[1:0];
         end
         2'b01: begin
            misalign = lat_addr[0];
            off      = {lat_addr[1], 1'b0};
            be       = 4'b0011 << {lat_addr[1], 1'b0};
         end
         default: begin
            misalign = |lat_addr[1:0];
            off      = 2'b00;
            be       = 4'b1111;
         end
      endcase
`ifdef DMEM_MISALIGN_TRAP_EN
      err = !func_ok || !range_ok || misalign;
`else
      err = !func_ok || !range_ok;
`endif
      idx      = lat_addr[AW+1:2];
      word     = mem[idx];
      byte_val = word[{off, 3'b000} +: 8];
      half_val = word[{off[1], 4'b0000} +: 16];
      case (lat_func3)
         3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
         3'b001:  load_data = {{16{half_val[15]}}, half_val};
         3'b100:  load_data = {24'd0, byte_val};
         3'b101:  load_data = {16'd0, half_val};
         default: load_data = word;
      endcase
      wmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      wdata_sh = lat_wdata << {off, 3'b000};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_func3 <= 3'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_func3 <= req_func3;
                  cnt       <= 4'(LATENCY - 1);
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rsp_err   <= err;
                  rsp_rdata <= (err || lat_we) ? 32'd0 : load_data;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Storage is deliberately outside the reset domain; reset forces IDLE so no write can slip through.
   always_ff @(posedge clk) begin
      if (access && lat_we && !err)
         mem[idx] <= (word & ~wmask) | (wdata_sh & wmask);
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder against a byte-level memory model.
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [2:0]  req_func3 = 3'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model_mem [DEPTH];

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Memory as an array of bytes inside words: applies the access and returns the expected response.
   function automatic void model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [2:0] f3, output logic [31:0] rd, output logic err);
      int          size;
      int          widx;
      int          off;
      logic [31:0] a;
      logic [31:0] word;
      logic [31:0] mask;
      logic [31:0] val;
      logic        legal;
      size  = 1 << f3[1:0];
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal;
      a     = addr;
      rd    = 32'd0;
      if (legal && (addr % 32'(size)) != 32'd0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
         err = 1'b1;
`else
         a = addr - (addr % 32'(size));
`endif
      end
      if ((addr >> 2) >= 32'(DEPTH)) err = 1'b1;
      if (err) return;
      widx = int'(a >> 2);
      off  = int'(a % 32'd4);
      word = model_mem[widx];
      if (we) begin
         for (int b = 0; b < size; b++) word[8*(off+b) +: 8] = wdata[8*b +: 8];
         model_mem[widx] = word;
      end else begin
         mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
         val  = (word >> (8*off)) & mask;
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
         rd = val;
      end
   endfunction

   task automatic drive_noise();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_func3 = 3'b010;
      req_addr  = 32'($urandom_range(0, 15)) << 2;
      req_wdata = $urandom;
   endtask

   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int stall, input string name,
                          output logic [31:0] got_rd, output logic got_err);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          k;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s idle: req_ready=%b want 1", name, req_ready);
      end
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_func3 = f3;
      @(posedge clk);
      model_access(we, addr, wdata, f3, exp_rd, exp_err);
      #1;
      k = 1;
      while (k <= 20) begin
         drive_noise();
         @(posedge clk);
         #1;
         if (rsp_valid === 1'b1) break;
         k++;
      end
      vectors++;
      if (k !== LAT) begin
         miscompares++;
         $display("[TB] FAIL %s latency: got %0d want %0d", name, k, LAT);
      end
      vectors++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, exp_err, exp_rd}) begin
         miscompares++;
         $display("[TB] FAIL %s response: valid=%b err=%b rdata=%h want valid=1 err=%b rdata=%h",
                  name, rsp_valid, rsp_err, rsp_rdata, exp_err, exp_rd);
      end
      got_rd  = rsp_rdata;
      got_err = rsp_err;
      for (int s = 0; s < stall; s++) begin
         drive_noise();
         @(posedge clk);
         #1;
         vectors++;
         if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp_err, exp_rd}) begin
            miscompares++;
            $display("[TB] FAIL %s stall%0d: valid=%b ready=%b err=%b rdata=%h want 1 0 %b %h",
                     name, s, rsp_valid, req_ready, rsp_err, rsp_rdata, exp_err, exp_rd);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      vectors++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL %s release: valid=%b ready=%b want 0 1", name, rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'hA5A5_A5A5;
      #23;
      vectors++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: valid=%b err=%b rdata=%h want all 0", rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ready: req_ready=%b want 1", req_ready);
      end
   endtask

   task automatic test_prefill();
      logic [31:0] rd;
      logic        e;
      for (int w = 0; w < 16; w++) run_txn(1'b1, 32'(w * 4), $urandom, 3'b010, 0, "prefill", rd, e);
   endtask

   task automatic test_basic_access();
      logic [31:0] rd;
      logic        e;
      logic [31:0] want [5];
      logic [31:0] addrs [5];
      logic [2:0]  f3s [5];
      want  = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'hDEAD55EF};
      addrs = '{32'h10, 32'h13, 32'h13, 32'h10, 32'h10};
      f3s   = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b010};
      run_txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, "sw_10", rd, e);
      vectors++;
      if (e !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sw_10_err: got %b want 0", e);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 4) run_txn(1'b1, 32'h11, 32'h55, 3'b000, 0, "sb_11", rd, e);
         run_txn(1'b0, addrs[i], 32'd0, f3s[i], 0, "load_const", rd, e);
         vectors++;
         if (rd !== want[i]) begin
            miscompares++;
            $display("[TB] FAIL load_const%0d: got %h want %h", i, rd, want[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] rd;
      logic        e;
      run_txn(1'b0, 32'h10, 32'd0, 3'b010, 5, "stall", rd, e);
   endtask

   task automatic test_misalign();
      logic [31:0] rd;
      logic        e;
      logic [32:0] want;
`ifdef DMEM_MISALIGN_TRAP_EN
      want = {1'b1, 32'd0};
`else
      want = {1'b0, 32'hDEAD55EF};
`endif
      run_txn(1'b0, 32'h12, 32'd0, 3'b010, 0, "lw_12", rd, e);
      vectors++;
      if ({e, rd} !== want) begin
         miscompares++;
         $display("[TB] FAIL lw_12: err=%b rdata=%h want err=%b rdata=%h", e, rd, want[32], want[31:0]);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        e;
      run_txn(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 3'b010, 0, "sw_oob", rd, e);
      vectors++;
      if (e !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL sw_oob_err: got %b want 1", e);
      end
      run_txn(1'b0, 32'h0, 32'd0, 3'b010, 0, "lw_0_after_oob", rd, e);
      run_txn(1'b0, 32'h10, 32'd0, 3'b011, 0, "ld_f3_011", rd, e);
      vectors++;
      if (e !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ld_f3_011_err: got %b want 1", e);
      end
      run_txn(1'b1, 32'h10, 32'h0BAD0BAD, 3'b100, 0, "st_f3_100", rd, e);
      run_txn(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw_10_after_bad_st", rd, e);
   endtask

   task automatic test_random();
      logic [31:0] rd;
      logic        e;
      logic [31:0] addr;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
         else                           addr = 32'($urandom_range(0, 63));
         run_txn(1'($urandom_range(0, 1)), addr, $urandom, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 2), "random", rd, e);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd;
      logic        e;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      req_func3 = 3'b010;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if (rsp_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_in_reset: rsp_valid=%b want 0", rsp_valid);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_release: req_ready=%b want 1", req_ready);
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_rsp%0d: rsp_valid=%b want 0", c, rsp_valid);
         end
      end
      run_txn(1'b0, 32'h20, 32'd0, 3'b010, 0, "lw_20_after_abort", rd, e);
   endtask

   initial begin
      $display("[TB] start: DEPTH_WORDS=%0d LATENCY=%0d", DEPTH, LAT);
      test_reset();
      test_prefill();
      test_basic_access();
      test_stall();
      test_misalign();
      test_errors();
      test_random();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
